// File: rtl/time_display_driver.sv
// Two-digit BCD seconds display driver: multiplexes a sampled time value onto a
// common-anode 7-segment pair with leading-zero blanking, warn blink and expiry.
module time_display_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_DIV   = 12500000,
    parameter logic [7:0]  WARN_BCD    = 8'h10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] time_left,
    input  logic       time_up,
    output logic [6:0] seg_n,
    output logic [1:0] an_n,
    output logic       warn
);

    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        SLOT_ONES = 1'b0,
        SLOT_TENS = 1'b1
    } slot_t;

    typedef enum logic [1:0] {
        MODE_NORMAL  = 2'd0,
        MODE_WARN    = 2'd1,
        MODE_EXPIRED = 2'd2
    } mode_t;

    logic [REF_W-1:0] refresh_cnt;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_on;
    logic [7:0]       snap;
    logic             up_snap;
    slot_t            slot_q;
    slot_t            slot_d;
    mode_t            mode;
    logic             refresh_wrap;
    logic             blink_wrap;
    logic [3:0]       digit;
    logic [1:0]       an_sel;
    logic [6:0]       seg_d;
    logic [1:0]       an_d;
    logic             warn_d;

    function automatic logic [6:0] enc7(input logic [3:0] d);
        case (d)
            4'd0:    enc7 = 7'b1000000;
            4'd1:    enc7 = 7'b1111001;
            4'd2:    enc7 = 7'b0100100;
            4'd3:    enc7 = 7'b0110000;
            4'd4:    enc7 = 7'b0011001;
            4'd5:    enc7 = 7'b0010010;
            4'd6:    enc7 = 7'b0000010;
            4'd7:    enc7 = 7'b1111000;
            4'd8:    enc7 = 7'b0000000;
            4'd9:    enc7 = 7'b0010000;
            default: enc7 = 7'b0111111;
        endcase
    endfunction

    assign refresh_wrap = (refresh_cnt == REF_LAST);
    assign blink_wrap   = (blink_cnt == BLK_LAST);

    // Slot state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            slot_q <= SLOT_ONES;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Counters and the per-pair snapshot (taken when tens slot hands back to ones)
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            refresh_cnt <= '0;
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
            snap        <= 8'h60;
            up_snap     <= 1'b0;
        end else begin
            refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + REF_W'(1);
            blink_cnt   <= blink_wrap ? '0 : blink_cnt + BLK_W'(1);
            if (blink_wrap) begin
                blink_on <= ~blink_on;
            end
            if (refresh_wrap && (slot_q == SLOT_TENS)) begin
                snap    <= time_left;
                up_snap <= time_up;
            end
        end
    end

    // Next slot, mode decode and display pattern
    always_comb begin
        slot_d = slot_q;
        mode   = MODE_NORMAL;
        seg_d  = SEG_BLANK;
        an_d   = 2'b11;
        warn_d = 1'b0;
        digit  = (slot_q == SLOT_ONES) ? snap[3:0] : snap[7:4];
        an_sel = (slot_q == SLOT_ONES) ? 2'b10 : 2'b01;

        if (refresh_wrap) begin
            slot_d = (slot_q == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
        end

        if (up_snap || (snap == 8'h00)) begin
            mode = MODE_EXPIRED;
        end else if (snap < WARN_BCD) begin
            mode = MODE_WARN;
        end

        if (mode == MODE_EXPIRED) begin
            seg_d = enc7(4'd0);
            an_d  = an_sel;
        end else if ((mode == MODE_WARN) && !blink_on) begin
            seg_d = SEG_BLANK;
            an_d  = 2'b11;
        end else if ((slot_q == SLOT_TENS) && (snap[7:4] == 4'd0)) begin
            seg_d = SEG_BLANK;
            an_d  = 2'b11;
        end else begin
            seg_d = enc7(digit);
            an_d  = an_sel;
        end

        warn_d = (mode == MODE_WARN);
    end

    // Registered display outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            seg_n <= SEG_BLANK;
            an_n  <= 2'b11;
            warn  <= 1'b0;
        end else begin
            seg_n <= seg_d;
            an_n  <= an_d;
            warn  <= warn_d;
        end
    end

endmodule
